// File: rtl/eth_rx_classifier.sv
// Ethernet-style receive classifier: routes each packet to one destination
// port by its 16-bit destination address, drops unmatched packets, flags
// runts/overlength/aborts and keeps saturating statistics counters.
module eth_rx_classifier #(
  parameter int unsigned                 DATA_W     = 32,
  parameter int unsigned                 NUM_PORTS  = 2,
  parameter logic [16*NUM_PORTS-1:0]     PORT_ADDRS = {16'hBEEF, 16'hABCD},
  parameter int unsigned                 MAX_WORDS  = 64,
  parameter int unsigned                 MIN_WORDS  = 3,
  parameter int unsigned                 CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 inValid,
  input  logic [DATA_W-1:0]    inData,
  input  logic                 inSop,
  input  logic                 inEop,
  input  logic                 clrCnt,
  output logic                 outWrEn,
  output logic [DATA_W+1:0]    outData,
  output logic [NUM_PORTS-1:0] outPortSel,
  output logic                 outErr,
  output logic                 outAbort,
  output logic [CNT_W-1:0]     pktCnt,
  output logic [CNT_W-1:0]     dropCnt,
  output logic [CNT_W-1:0]     errCnt
);

  localparam int unsigned   WC_W  = $clog2(MAX_WORDS + 1);
  localparam logic [WC_W-1:0] MAX_C = WC_W'(MAX_WORDS);
  localparam logic [WC_W-1:0] MIN_C = WC_W'(MIN_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    PKT,
    DROP,
    TRUNC
  } state_t;

  state_t                state, nState;
  logic [WC_W-1:0]       wordCnt, nCnt, curCnt;
  logic [NUM_PORTS-1:0]  selReg, nSelReg, fwdSel;
  logic [NUM_PORTS-1:0]  matchSel;
  logic                  matchHit;
  logic                  fwd, eopBit;
  logic                  nWrEn, nErr, nAbort;
  logic [DATA_W+1:0]     nData;
  logic [NUM_PORTS-1:0]  nPortSel;
  logic                  incPkt, incDrop, incErr;

  // Address lookup: lowest-index port wins when addresses are duplicated.
  always_comb begin
    matchSel = '0;
    matchHit = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (!matchHit && (inData[15:0] == PORT_ADDRS[16*i +: 16])) begin
        matchSel[i] = 1'b1;
        matchHit    = 1'b1;
      end
    end
  end

  // Next-state, next-output and counter-increment decode.
  always_comb begin
    nState   = state;
    nCnt     = wordCnt;
    nSelReg  = selReg;
    nWrEn    = 1'b0;
    nErr     = 1'b0;
    nAbort   = 1'b0;
    nData    = outData;
    nPortSel = '0;
    incPkt   = 1'b0;
    incDrop  = 1'b0;
    incErr   = 1'b0;
    fwd      = 1'b0;
    fwdSel   = selReg;
    eopBit   = 1'b0;
    curCnt   = inSop ? WC_W'(1) : (wordCnt + 1'b1);

    if (inValid) begin
      if (inSop) begin
        // A Sop always reclassifies; it aborts only an open forwarded packet.
        if (state == PKT) begin
          nAbort = 1'b1;
          incErr = 1'b1;
        end
        if (matchHit) begin
          fwd     = 1'b1;
          fwdSel  = matchSel;
          nSelReg = matchSel;
        end else begin
          incDrop = 1'b1;
          nState  = DROP;
          nCnt    = '0;
        end
      end else begin
        unique case (state)
          IDLE:    incErr = 1'b1;
          PKT:     fwd    = 1'b1;
          default: begin
            if (inEop) begin
              nState = IDLE;
            end
          end
        endcase
      end

      // Shared handling of any forwarded word (new Sop or continuation),
      // so a Sop+Eop runt and a MAX_WORDS of 1 fall out of the same checks.
      if (fwd) begin
        nWrEn    = 1'b1;
        nPortSel = fwdSel;
        eopBit   = inEop;
        if (inEop) begin
          nState = IDLE;
          nCnt   = '0;
          if (curCnt < MIN_C) begin
            nErr   = 1'b1;
            incErr = 1'b1;
          end else begin
            incPkt = 1'b1;
          end
        end else if (curCnt == MAX_C) begin
          eopBit = 1'b1;
          nErr   = 1'b1;
          incErr = 1'b1;
          nState = TRUNC;
          nCnt   = '0;
        end else begin
          nState = PKT;
          nCnt   = curCnt;
        end
        nData = {eopBit, inSop, inData};
      end
    end
  end

  // State, word count, latched select and registered outputs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      wordCnt    <= '0;
      selReg     <= '0;
      outWrEn    <= 1'b0;
      outData    <= '0;
      outPortSel <= '0;
      outErr     <= 1'b0;
      outAbort   <= 1'b0;
    end else begin
      state      <= nState;
      wordCnt    <= nCnt;
      selReg     <= nSelReg;
      outWrEn    <= nWrEn;
      outData    <= nData;
      outPortSel <= nPortSel;
      outErr     <= nErr;
      outAbort   <= nAbort;
    end
  end

  // Saturating statistics counters; clear has priority over increment.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pktCnt  <= '0;
      dropCnt <= '0;
      errCnt  <= '0;
    end else if (clrCnt) begin
      pktCnt  <= '0;
      dropCnt <= '0;
      errCnt  <= '0;
    end else begin
      if (incPkt && (pktCnt != '1)) begin
        pktCnt <= pktCnt + 1'b1;
      end
      if (incDrop && (dropCnt != '1)) begin
        dropCnt <= dropCnt + 1'b1;
      end
      if (incErr && (errCnt != '1)) begin
        errCnt <= errCnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/eth_rx_classifier.md
ETH_RX_CLASSIFIER -- requirements
Module: eth_rx_classifier

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning data word width (>=16).
REQ-002 SHALL have parameter NUM_PORTS, default 2, meaning number of destination ports.
REQ-003 SHALL have parameter PORT_ADDRS, default {16'hBEEF,16'hABCD}, meaning packed 16-bit address per port (port i in bits [16i+15:16i]).
REQ-004 SHALL have parameter MAX_WORDS, default 64, meaning longest legal packet in words.
REQ-005 SHALL have parameter MIN_WORDS, default 3, meaning shortest legal packet in words (dest, src, data).
REQ-006 SHALL have parameter CNT_W, default 16, meaning statistics counter width.
REQ-007 SHALL have ports: clk  in  1  clock, rising edge; the block uses one clock and reset is asynchronous, active-low.
REQ-008 resetN  in  1  asynchronous active-low reset.
REQ-009 inValid  in  1  input word qualifier; inData/inSop/inEop ignored when 0.
REQ-010 inData  in  DATA_W  input word; first word of packet carries dest address in [15:0].
REQ-011 inSop / inEop  in  1 each  start/end of packet markers.
REQ-012 clrCnt  in  1  synchronous clear of all counters.
REQ-013 outWrEn  out  1  output word valid.
REQ-014 outData  out  DATA_W+2  {eop, sop, data}.
REQ-015 outPortSel  out  NUM_PORTS  one-hot destination, valid with outWrEn, else 0.
REQ-016 outErr  out  1  packet error, asserted only on the eop word; outAbort  out  1  previous open packet aborted.
REQ-017 pktCnt / dropCnt / errCnt  out  CNT_W each  good packets / unmatched packets / error events.

Function
REQ-018 SHALL implement states IDLE, PKT (forwarding), DROP (discarding unmatched), TRUNC (discarding overlength tail).
REQ-019 Every forwarded word SHALL appear on outputs exactly 1 cycle after its accepted input cycle; no other latency.
REQ-020 IDLE + valid Sop: compare inData[15:0] to all PORT_ADDRS; match -> forward word, latch one-hot select (lowest index wins on duplicates), word count=1, go PKT; no match -> no write, dropCnt+1, go DROP.
REQ-021 IDLE + valid non-Sop word (including orphan Eop): discard, errCnt+1, stay IDLE.
REQ-022 PKT: each valid word forwarded with latched select, count+1; on inEop go IDLE.
REQ-023 Runt: Eop word with count < MIN_WORDS SHALL be forwarded with outErr=1, errCnt+1, pktCnt unchanged; Sop and Eop same cycle is a 1-word runt.
REQ-024 Normal end: Eop with MIN_WORDS <= count <= MAX_WORDS -> outErr=0, pktCnt+1.
REQ-025 Overlength: word number MAX_WORDS without inEop SHALL be forwarded with eop bit forced 1 and outErr=1, errCnt+1, go TRUNC.
REQ-026 TRUNC/DROP: discard valid words; on inEop go IDLE; valid Sop restarts classification as in REQ-020 (no error).
REQ-027 Sop during PKT: outAbort=1 for one cycle together with the new Sop word's output cycle (word written only if new packet matches), errCnt+1, reclassify per REQ-020.
REQ-028 inValid=0 cycles SHALL not change state, count or outputs other than outWrEn=0 and outPortSel=0.
REQ-029 Counters SHALL increment by at most 1 per cycle per counter, saturate at all ones, clrCnt wins over simultaneous increment.

Reset
REQ-030 resetN low SHALL asynchronously force state IDLE, word count 0, outWrEn/outErr/outAbort 0, outData 0, outPortSel 0, all counters 0; a packet in progress is abandoned with no further output.
REQ-031 First Sop after reset release SHALL be classified normally; non-Sop words before it follow REQ-021.

Verification
REQ-032 4-word packet dest 0xABCD -> 4 writes one cycle delayed, outPortSel=01, sop on word1, eop on word4, outErr=0, pktCnt=1.
REQ-033 Packet dest 0x1234 -> no writes, dropCnt=1, following 0xBEEF packet forwarded with outPortSel=10.
REQ-034 Sop+Eop same cycle to 0xABCD -> one write with sop=eop=1, outErr=1, errCnt=1, pktCnt=0.
REQ-035 MAX_WORDS=64, 70-word packet -> 64 writes, word64 eop=1 outErr=1, words 65-70 dropped, errCnt=1.
REQ-036 Sop at word 3 of open packet -> outAbort pulse aligned with new sop write, errCnt=1; resetN low mid-packet -> outputs 0 immediately, counters 0.
